weight_mem_bank: RTL and testbench



---
 rtl/weight_mem_bank_if.sv | 33 +++
 rtl/weight_mem_bank.sv | 123 ++++++++++++
 tb/tb_weight_mem_bank.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/weight_mem_bank_if.sv
// Bus bundle for weight_mem_bank: per-bank burst-read controls and results,
// plus the shared weight write port. Per-bank fields are flattened, bank b at [b*W +: W].
interface weight_mem_bank_if #(
  parameter int NUM_BANKS      = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 64,
  parameter int BURST_WIDTH    = 8,
  parameter int BANK_SEL_WIDTH = 4
);
  logic [NUM_BANKS-1:0]             rd_start;
  logic [NUM_BANKS*ADDR_WIDTH-1:0]  rd_base;
  logic [NUM_BANKS*BURST_WIDTH-1:0] rd_len;
  logic [NUM_BANKS-1:0]             rd_pause;
  logic [NUM_BANKS-1:0]             rd_busy;
  logic [NUM_BANKS-1:0]             rd_done;
  logic [NUM_BANKS*DATA_WIDTH-1:0]  data_out;
  logic [NUM_BANKS-1:0]             data_valid;
  logic [NUM_BANKS-1:0]             data_last;
  logic                             wr_en;
  logic [BANK_SEL_WIDTH-1:0]        wr_bank;
  logic [ADDR_WIDTH-1:0]            wr_addr;
  logic [DATA_WIDTH-1:0]            wr_data;

  modport master (
    output rd_start, rd_base, rd_len, rd_pause, wr_en, wr_bank, wr_addr, wr_data,
    input  rd_busy, rd_done, data_out, data_valid, data_last
  );

  modport slave (
    input  rd_start, rd_base, rd_len, rd_pause, wr_en, wr_bank, wr_addr, wr_data,
    output rd_busy, rd_done, data_out, data_valid, data_last
  );
endinterface

// File: rtl/weight_mem_bank.sv
// Multi-bank weight store: each bank is a read-first synchronous RAM with its own
// burst-read engine (base + length, pausable); one shared write port reloads weights.
module weight_mem_bank_lane #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base,
  input  logic [BURST_WIDTH-1:0] len,
  input  logic                   pause,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   valid,
  output logic                   last
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state, state_nx;
  logic [ADDR_WIDTH-1:0]  addr, addr_nx;
  logic [BURST_WIDTH-1:0] cnt, cnt_nx;
  logic                   issue, issue_last;

  logic [DATA_WIDTH-1:0]  mem [2**ADDR_WIDTH];

  always_comb begin
    state_nx   = state;
    addr_nx    = addr;
    cnt_nx     = cnt;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state)
      IDLE: begin
        // zero-length starts never enter BURST
        if (start && len != '0) begin
          addr_nx  = base;
          cnt_nx   = len;
          state_nx = BURST;
        end
      end
      BURST: begin
        if (!pause) begin
          issue   = 1'b1;
          addr_nx = addr + 1'b1;
          cnt_nx  = cnt - 1'b1;
          if (cnt == BURST_WIDTH'(1)) begin
            issue_last = 1'b1;
            state_nx   = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      dout  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      cnt   <= cnt_nx;
      valid <= issue;
      last  <= issue_last;
      if (issue) dout <= mem[addr];
    end
  end

  // No reset on the array: weights survive a datapath reset. Read above sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign busy = (state == BURST);
  assign done = last;
endmodule

module weight_mem_bank #(
  parameter int NUM_BANKS      = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 64,
  parameter int BURST_WIDTH    = 8,
  parameter int BANK_SEL_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  weight_mem_bank_if.slave  bus
);
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    // out-of-range wr_bank matches no lane, so the write is dropped
    weight_mem_bank_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BURST_WIDTH(BURST_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .start(bus.rd_start[b]),
      .base (bus.rd_base[b*ADDR_WIDTH +: ADDR_WIDTH]),
      .len  (bus.rd_len[b*BURST_WIDTH +: BURST_WIDTH]),
      .pause(bus.rd_pause[b]),
      .we   (bus.wr_en && (bus.wr_bank == BANK_SEL_WIDTH'(b))),
      .waddr(bus.wr_addr),
      .wdata(bus.wr_data),
      .busy (bus.rd_busy[b]),
      .done (bus.rd_done[b]),
      .dout (bus.data_out[b*DATA_WIDTH +: DATA_WIDTH]),
      .valid(bus.data_valid[b]),
      .last (bus.data_last[b])
    );
  end
endmodule

// File: tb/tb_weight_mem_bank.sv
// Directed bench for weight_mem_bank: burst timing, wrap, pause, ignored starts,
// read-first collision, dropped writes and mid-burst reset.
module tb_weight_mem_bank;
  localparam int NB = 8;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int SW = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  weight_mem_bank_if #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .BURST_WIDTH(BW), .BANK_SEL_WIDTH(SW)) bus ();

  weight_mem_bank #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .BURST_WIDTH(BW), .BANK_SEL_WIDTH(SW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one clock; outputs are then observed 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int b, input int a, input logic [63:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_bank = SW'(b);
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic set_start(input int b, input int base, input int len);
    bus.rd_start[b]          = 1'b1;
    bus.rd_base[b*AW +: AW]  = AW'(base);
    bus.rd_len[b*BW +: BW]   = BW'(len);
  endtask

  task automatic cyc(input string tag, input int b, input logic v, input logic l,
                     input logic [63:0] d);
    chk({tag, "_valid"}, 64'(bus.data_valid[b]), 64'(v));
    chk({tag, "_last"},  64'(bus.data_last[b]),  64'(l));
    chk({tag, "_done"},  64'(bus.rd_done[b]),    64'(l));
    if (v) chk({tag, "_data"}, bus.data_out[b*DW +: DW], d);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.rd_start = '0; bus.rd_base = '0; bus.rd_len = '0; bus.rd_pause = '0;
    bus.wr_en = 1'b0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0;
    tick(); tick();
    chk("rst_busy",  64'(bus.rd_busy), 64'(0));
    chk("rst_valid", 64'(bus.data_valid), 64'(0));
    chk("rst_dout",  64'(|bus.data_out), 64'(0));
    rst = 1'b1;

    // basic 4-word burst on bank 0
    wr(0, 0, 64'h11); wr(0, 1, 64'h22); wr(0, 2, 64'h33); wr(0, 3, 64'h44);
    set_start(0, 0, 4); tick(); bus.rd_start = '0;
    chk("b0_busy_t1", 64'(bus.rd_busy[0]), 64'(1));
    cyc("b0_t1", 0, 1'b0, 1'b0, 0);
    tick(); cyc("b0_w0", 0, 1'b1, 1'b0, 64'h11);
    tick(); cyc("b0_w1", 0, 1'b1, 1'b0, 64'h22);
    tick(); cyc("b0_w2", 0, 1'b1, 1'b0, 64'h33);
    chk("b0_busy_t4", 64'(bus.rd_busy[0]), 64'(1));
    tick(); cyc("b0_w3", 0, 1'b1, 1'b1, 64'h44);
    chk("b0_busy_t5", 64'(bus.rd_busy[0]), 64'(0));
    tick(); cyc("b0_after", 0, 1'b0, 1'b0, 0);
    chk("b0_hold", bus.data_out[0 +: DW], 64'h44);

    // address wrap on bank 3
    wr(3, 10'h3FE, 64'hA0); wr(3, 10'h3FF, 64'hA1); wr(3, 0, 64'hA2); wr(3, 1, 64'hA3);
    set_start(3, 10'h3FE, 4); tick(); bus.rd_start = '0;
    tick(); cyc("wrap_w0", 3, 1'b1, 1'b0, 64'hA0);
    tick(); cyc("wrap_w1", 3, 1'b1, 1'b0, 64'hA1);
    tick(); cyc("wrap_w2", 3, 1'b1, 1'b0, 64'hA2);
    tick(); cyc("wrap_w3", 3, 1'b1, 1'b1, 64'hA3);

    // pause one cycle after the first issue on bank 1
    wr(1, 0, 64'hB0); wr(1, 1, 64'hB1); wr(1, 2, 64'hB2);
    set_start(1, 0, 3); tick(); bus.rd_start = '0;
    tick(); cyc("pau_w0", 1, 1'b1, 1'b0, 64'hB0);
    bus.rd_pause[1] = 1'b1;
    tick(); cyc("pau_gap", 1, 1'b0, 1'b0, 0);
    chk("pau_busy", 64'(bus.rd_busy[1]), 64'(1));
    bus.rd_pause[1] = 1'b0;
    tick(); cyc("pau_w1", 1, 1'b1, 1'b0, 64'hB1);
    tick(); cyc("pau_w2", 1, 1'b1, 1'b1, 64'hB2);

    // restart attempt while busy on bank 2 is ignored
    wr(2, 0, 64'hC0); wr(2, 1, 64'hC1); wr(2, 2, 64'hC2); wr(2, 8, 64'hCC);
    set_start(2, 0, 3); tick();
    set_start(2, 8, 2); tick(); bus.rd_start = '0;
    cyc("rs_w0", 2, 1'b1, 1'b0, 64'hC0);
    tick(); cyc("rs_w1", 2, 1'b1, 1'b0, 64'hC1);
    tick(); cyc("rs_w2", 2, 1'b1, 1'b1, 64'hC2);
    tick(); cyc("rs_end", 2, 1'b0, 1'b0, 0);
    chk("rs_busy", 64'(bus.rd_busy[2]), 64'(0));

    // zero-length start on bank 4
    set_start(4, 0, 0); tick(); bus.rd_start = '0;
    chk("len0_busy", 64'(bus.rd_busy[4]), 64'(0));
    tick(); cyc("len0", 4, 1'b0, 1'b0, 0);

    // read-first collision on bank 6
    wr(6, 0, 64'h55);
    set_start(6, 0, 1); tick(); bus.rd_start = '0;
    wr(6, 0, 64'hAA);
    cyc("rf_old", 6, 1'b1, 1'b1, 64'h55);
    set_start(6, 0, 1); tick(); bus.rd_start = '0;
    tick(); cyc("rf_new", 6, 1'b1, 1'b1, 64'hAA);

    // wr_bank == NUM_BANKS is dropped (must not alias onto bank 0)
    wr(NB, 0, 64'hDEAD);
    set_start(0, 0, 1); tick(); bus.rd_start = '0;
    tick(); cyc("drop_b0", 0, 1'b1, 1'b1, 64'h11);

    // mid-burst reset on banks 0 and 5
    wr(5, 0, 64'hE0); wr(5, 1, 64'hE1); wr(5, 2, 64'hE2); wr(5, 3, 64'hE3);
    set_start(0, 0, 4); set_start(5, 0, 4); tick(); bus.rd_start = '0;
    tick(); cyc("mr_b0", 0, 1'b1, 1'b0, 64'h11); cyc("mr_b5", 5, 1'b1, 1'b0, 64'hE0);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("mr_busy",  64'(bus.rd_busy), 64'(0));
    chk("mr_valid", 64'(bus.data_valid), 64'(0));
    chk("mr_last",  64'(bus.data_last), 64'(0));
    chk("mr_done",  64'(bus.rd_done), 64'(0));
    chk("mr_dout",  64'(|bus.data_out), 64'(0));
    tick(); chk("mr_valid2", 64'(bus.data_valid), 64'(0));
    tick(); chk("mr_valid3", 64'(bus.data_valid), 64'(0));
    set_start(0, 2, 1); set_start(5, 3, 1); tick(); bus.rd_start = '0;
    tick(); cyc("ret_b0", 0, 1'b1, 1'b1, 64'h33); cyc("ret_b5", 5, 1'b1, 1'b1, 64'hE3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
